// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port, byte-masked data memory between two masters.
// Define DMEM_ARB_STATS_EN to add grant/conflict counters (stat_gnt0, stat_gnt1, stat_conflict).
module dmem_arbiter #(
  parameter int unsigned ADDR_W    = 30,
  parameter logic        INIT_LAST = 1'b1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              m0_valid,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [31:0]       m0_wdata,
  input  logic [3:0]        m0_wmask,
  output logic              m0_ready,
  output logic [31:0]       m0_rdata,
  input  logic              m1_valid,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_wdata,
  input  logic [3:0]        m1_wmask,
  output logic              m1_ready,
  output logic [31:0]       m1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wmask,
  input  logic [31:0]       mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [31:0]       stat_gnt0,
  output logic [31:0]       stat_gnt1,
  output logic [31:0]       stat_conflict
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e              state_q;
  logic                last_q;
  logic                gnt_q;
  logic [ADDR_W-1:0]   req_addr_q;
  logic [31:0]         req_wdata_q;
  logic [3:0]          req_wmask_q;
  logic                m0_ready_q;
  logic                m1_ready_q;
  logic [31:0]         m0_rdata_q;
  logic [31:0]         m1_rdata_q;

  logic                elig0;
  logic                elig1;
  logic                req0;
  logic                req1;
  logic                capture;
  logic                win_d;
  logic [ADDR_W-1:0]   cap_addr_d;
  logic [31:0]         cap_wdata_d;
  logic [3:0]          cap_wmask_d;

  // A port just acknowledged in RESP may still hold valid, so only the other port may bid there.
  always_comb begin
    elig0       = (state_q == IDLE) || ((state_q == RESP) && gnt_q);
    elig1       = (state_q == IDLE) || ((state_q == RESP) && !gnt_q);
    req0        = m0_valid && elig0;
    req1        = m1_valid && elig1;
    capture     = req0 || req1;
    win_d       = (req0 && req1) ? !last_q : req1;
    cap_addr_d  = win_d ? m1_addr  : m0_addr;
    cap_wdata_d = win_d ? m1_wdata : m0_wdata;
    cap_wmask_d = win_d ? m1_wmask : m0_wmask;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      last_q      <= INIT_LAST;
      gnt_q       <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_wmask_q <= '0;
      m0_ready_q  <= 1'b0;
      m1_ready_q  <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
    end else begin
      m0_ready_q <= 1'b0;
      m1_ready_q <= 1'b0;
      case (state_q)
        IDLE, RESP: begin
          if (capture) begin
            state_q     <= EXEC;
            gnt_q       <= win_d;
            last_q      <= win_d;
            req_addr_q  <= cap_addr_d;
            req_wdata_q <= cap_wdata_d;
            req_wmask_q <= cap_wmask_d;
          end else begin
            state_q <= IDLE;
          end
        end
        EXEC: begin
          state_q <= RESP;
          if (gnt_q) begin
            m1_ready_q <= 1'b1;
            m1_rdata_q <= mem_rdata;
          end else begin
            m0_ready_q <= 1'b1;
            m0_rdata_q <= mem_rdata;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Address and data stay parked on the last request; only the strobe is gated by EXEC.
  assign mem_addr  = req_addr_q;
  assign mem_wdata = req_wdata_q;
  assign mem_wmask = (state_q == EXEC) ? req_wmask_q : 4'b0000;

  assign m0_ready  = m0_ready_q;
  assign m1_ready  = m1_ready_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;

`ifdef DMEM_ARB_STATS_EN
  logic [31:0] stat_gnt0_q;
  logic [31:0] stat_gnt1_q;
  logic [31:0] stat_conflict_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stat_gnt0_q     <= '0;
      stat_gnt1_q     <= '0;
      stat_conflict_q <= '0;
    end else if (capture) begin
      if (win_d) stat_gnt1_q <= stat_gnt1_q + 32'd1;
      else       stat_gnt0_q <= stat_gnt0_q + 32'd1;
      if (req0 && req1) stat_conflict_q <= stat_conflict_q + 32'd1;
    end
  end

  assign stat_gnt0     = stat_gnt0_q;
  assign stat_gnt1     = stat_gnt1_q;
  assign stat_conflict = stat_conflict_q;
`endif

endmodule
